// File: rtl/robo_step_scheduler.sv
// Robot step scheduler: turns gamepad button levels and VGA frames into a timed
// robo_tick cadence, followed by a sensor settle window and a req/ack map update.
//
// state       | meaning
// ST_PAUSE    | idle, waiting for Start (auto mode) or A (single step)
// ST_WAIT_FRM | auto mode, counting frame edges up to the selected period
// ST_TICK     | one-cycle robo_tick, step_count advances
// ST_SETTLE   | sensors settle for SETTLE_CYC cycles
// ST_UPDATE   | upd_req held until upd_ack or timeout
module robo_step_scheduler #(
  parameter int FRAME_BASE  = 32,
  parameter int SPEED_INIT  = 1,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clock50_i,
  input  logic        reset_n_i,
  input  logic        v_sync_i,
  input  logic [11:0] botoes_i,
  input  logic        upd_ack_i,
  output logic        robo_tick_o,
  output logic        upd_req_o,
  output logic        running_o,
  output logic        error_o,
  output logic [2:0]  speed_idx_o,
  output logic [15:0] step_count_o
);

  localparam int FW = $clog2(FRAME_BASE);
  localparam int TW = $clog2(TIMEOUT_CYC + SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    ST_PAUSE,
    ST_WAIT_FRM,
    ST_TICK,
    ST_SETTLE,
    ST_UPDATE
  } state_t;

  state_t state_q, state_d;

  logic          vs_meta_q, vs_sync_q, vs_prev_q;
  logic [3:0]    btn_q, btn_prev_q;
  logic          running_q, running_d;
  logic          error_q, error_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   step_count_q, step_count_d;
  logic [2:0]    speed_idx_q, speed_idx_d;

  logic          frame_edge;
  logic [3:0]    btn_edge;
  logic          start_e, a_e, up_e, dn_e;
  logic [FW:0]   period_m1;
  logic          frame_done;
  logic          keep_running;
  logic          unused_btn;

  assign unused_btn = ^botoes_i[11:4];

  // v_sync idles high, so the synchronizer resets high to avoid a false frame edge
  always_ff @(posedge clock50_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vs_meta_q  <= 1'b1;
      vs_sync_q  <= 1'b1;
      vs_prev_q  <= 1'b1;
      btn_q      <= '0;
      btn_prev_q <= '0;
    end else begin
      vs_meta_q  <= v_sync_i;
      vs_sync_q  <= vs_meta_q;
      vs_prev_q  <= vs_sync_q;
      btn_q      <= botoes_i[3:0];
      btn_prev_q <= btn_q;
    end
  end

  assign frame_edge = vs_prev_q & ~vs_sync_q;
  assign btn_edge   = btn_q & ~btn_prev_q;
  assign start_e    = btn_edge[0];
  assign a_e        = btn_edge[1];
  assign up_e       = btn_edge[2];
  assign dn_e       = btn_edge[3];

  assign period_m1    = (FW+1)'(FRAME_BASE >> speed_idx_q) - (FW+1)'(1);
  assign frame_done   = {1'b0, frame_cnt_q} >= period_m1;
  assign keep_running = running_q & ~start_e;

  always_ff @(posedge clock50_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_PAUSE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSE: begin
        if (start_e)  state_d = ST_WAIT_FRM;
        else if (a_e) state_d = ST_TICK;
      end
      ST_WAIT_FRM: begin
        if (start_e)                       state_d = ST_PAUSE;
        else if (frame_edge && frame_done) state_d = ST_TICK;
      end
      ST_TICK:   state_d = ST_SETTLE;
      ST_SETTLE: if (timer_q == '0) state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (upd_ack_i)          state_d = keep_running ? ST_WAIT_FRM : ST_PAUSE;
        else if (timer_q == '0) state_d = ST_PAUSE;
      end
      default:   state_d = ST_PAUSE;
    endcase
  end

  always_comb begin
    robo_tick_o = (state_q == ST_TICK);
    upd_req_o   = (state_q == ST_UPDATE);
  end

  always_comb begin
    running_d    = running_q;
    error_d      = error_q;
    frame_cnt_d  = frame_cnt_q;
    timer_d      = timer_q;
    step_count_d = step_count_q;
    speed_idx_d  = speed_idx_q;

    if (up_e && !dn_e && speed_idx_q < 3'd5)      speed_idx_d = speed_idx_q + 3'd1;
    else if (dn_e && !up_e && speed_idx_q != '0)  speed_idx_d = speed_idx_q - 3'd1;

    case (state_q)
      ST_PAUSE: begin
        if (start_e) begin
          running_d   = 1'b1;
          frame_cnt_d = '0;
        end
      end
      ST_WAIT_FRM: begin
        if (start_e)         running_d   = 1'b0;
        else if (frame_edge) frame_cnt_d = frame_done ? '0 : frame_cnt_q + 1'b1;
      end
      ST_TICK: begin
        running_d    = keep_running;
        step_count_d = step_count_q + 16'd1;
        timer_d      = TW'(SETTLE_CYC - 1);
      end
      ST_SETTLE: begin
        running_d = keep_running;
        timer_d   = (timer_q == '0) ? TW'(TIMEOUT_CYC - 1) : timer_q - 1'b1;
      end
      ST_UPDATE: begin
        running_d = keep_running;
        if (upd_ack_i) begin
          frame_cnt_d = '0;
        end else if (timer_q == '0) begin
          error_d   = 1'b1;
          running_d = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock50_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      running_q    <= 1'b0;
      error_q      <= 1'b0;
      frame_cnt_q  <= '0;
      timer_q      <= '0;
      step_count_q <= '0;
      speed_idx_q  <= 3'(SPEED_INIT);
    end else begin
      running_q    <= running_d;
      error_q      <= error_d;
      frame_cnt_q  <= frame_cnt_d;
      timer_q      <= timer_d;
      step_count_q <= step_count_d;
      speed_idx_q  <= speed_idx_d;
    end
  end

  assign running_o    = running_q;
  assign error_o      = error_q;
  assign speed_idx_o  = speed_idx_q;
  assign step_count_o = step_count_q;

endmodule

// File: tb/tb_robo_step_scheduler.sv
// Self-checking bench for robo_step_scheduler: randomized speeds, ack delays and
// frame counts, checked against frame/press arithmetic and handshake timing rules.
module tb_robo_step_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_sync = 1'b1;
  logic [11:0] botoes = '0;
  logic        upd_ack = 1'b0;
  logic        robo_tick, upd_req, running, error;
  logic [2:0]  speed_idx;
  logic [15:0] step_count;

  localparam logic [11:0] B_START = 12'h001;
  localparam logic [11:0] B_A     = 12'h002;
  localparam logic [11:0] B_UP    = 12'h004;
  localparam logic [11:0] B_DN    = 12'h008;

  robo_step_scheduler dut (
    .clock50_i   (clk),
    .reset_n_i   (rst_n),
    .v_sync_i    (v_sync),
    .botoes_i    (botoes),
    .upd_ack_i   (upd_ack),
    .robo_tick_o (robo_tick),
    .upd_req_o   (upd_req),
    .running_o   (running),
    .error_o     (error),
    .speed_idx_o (speed_idx),
    .step_count_o(step_count)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ack responder and event monitor, evaluated on the falling edge
  int   cyc_n = 0, tick_cnt = 0, tick_cyc = 0, req_run = 0, req_width = 0;
  int   ack_mode = 1, ack_dly = 2;
  logic req_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc_n++;
    check("tick_req_excl", {31'd0, robo_tick & upd_req}, 32'd0);
    if (robo_tick) begin
      tick_cnt++;
      tick_cyc = cyc_n;
    end
    if (upd_req) req_run++;
    if (upd_req && !req_prev) check("tick_to_req", cyc_n - tick_cyc, 5);
    if (!upd_req && req_prev) req_width = req_run;
    if (!upd_req) req_run = 0;
    req_prev = upd_req;
    case (ack_mode)
      0:       upd_ack = 1'b0;
      1:       upd_ack = upd_req && (req_run > ack_dly);
      default: upd_ack = 1'b1;
    endcase
  end

  int spd_m = 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [11:0] m, input int hold);
    botoes = m;
    cyc(hold);
    botoes = '0;
    cyc(2);
  endtask

  task automatic frame();
    v_sync = 1'b0;
    cyc(4);
    v_sync = 1'b1;
    cyc(26);
  endtask

  // kind: 0 = Up, 1 = Down, 2 = Up+Down together
  task automatic speed_press(input int kind);
    press(kind == 0 ? B_UP : kind == 1 ? B_DN : (B_UP | B_DN), 2);
    if (kind == 0 && spd_m < 5) spd_m++;
    if (kind == 1 && spd_m > 0) spd_m--;
    check("speed", speed_idx, spd_m);
  endtask

  task automatic set_speed(input int s);
    while (spd_m > s) speed_press(1);
    while (spd_m < s) speed_press(0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s, p, f, u, w;
    logic [15:0] sc0;

    cyc(3);
    check("rst_tick", robo_tick, 0);
    check("rst_req", upd_req, 0);
    check("rst_running", running, 0);
    check("rst_error", error, 0);
    check("rst_speed", speed_idx, 1);
    check("rst_steps", step_count, 0);
    rst_n = 1'b1;
    cyc(2);

    // A held for 100 cycles gives exactly one step
    ack_mode = 1;
    ack_dly  = $urandom_range(0, 3);
    t0 = tick_cnt;
    press(B_A, 100);
    cyc(20);
    check("a_hold_ticks", tick_cnt - t0, 1);
    check("a_hold_running", running, 0);
    check("a_hold_steps", step_count, 1);
    check("a_hold_req_idle", upd_req, 0);
    check("a_hold_req_width", req_width, ack_dly + 1);

    // ack already high when UPDATE is entered
    ack_mode = 2;
    press(B_A, 2);
    cyc(20);
    check("ack_high_width", req_width, 1);
    check("ack_high_steps", step_count, 2);
    ack_mode = 1;

    repeat (7) speed_press(0);
    speed_press(2);
    for (int i = 0; i < 16; i++) speed_press($urandom_range(0, 2));

    // auto stepping: one tick per period frame edges
    for (int r = 0; r < 3; r++) begin
      s = (r == 0) ? 1 : $urandom_range(0, 5);
      set_speed(s);
      p = 32 >> s;
      ack_dly = $urandom_range(0, 3);
      t0  = tick_cnt;
      sc0 = step_count;
      press(B_START, 2);
      check("start_running", running, 1);
      for (int k = 1; k <= 2 * p; k++) begin
        frame();
        check("frame_ticks", tick_cnt - t0, k / p);
      end
      check("auto_steps", 16'(step_count - sc0), 2);
      check("auto_req_width", req_width, ack_dly + 1);
      press(B_START, 2);
      cyc(5);
      check("stop_running", running, 0);
      frame();
      frame();
      check("paused_no_tick", tick_cnt - t0, 2);
    end

    // lowering the period mid-count ticks on the next frame edge
    set_speed(0);
    f = $urandom_range(8, 30);
    u = $urandom_range(2, 5);
    t0 = tick_cnt;
    press(B_START, 2);
    repeat (f) frame();
    check("slow_no_tick", tick_cnt - t0, 0);
    repeat (u) speed_press(0);
    frame();
    check("speedup_tick", tick_cnt - t0, 1);
    press(B_START, 2);
    cyc(5);
    check("speedup_stop", running, 0);

    // handshake timeout
    ack_mode = 0;
    set_speed(5);
    press(B_START, 2);
    check("to_running", running, 1);
    frame();
    w = 0;
    while (!error && w < 1200) begin
      cyc(1);
      w++;
    end
    check("to_reached", w < 1200, 1);
    cyc(1);
    check("to_error", error, 1);
    check("to_req", upd_req, 0);
    check("to_running_clr", running, 0);
    check("to_req_width", req_width, 1000);

    ack_mode = 1;
    t0  = tick_cnt;
    sc0 = step_count;
    press(B_A, 2);
    cyc(20);
    check("err_step_tick", tick_cnt - t0, 1);
    check("err_step_count", 16'(step_count - sc0), 1);
    check("err_sticky", error, 1);

    // reset in the middle of UPDATE
    ack_mode = 0;
    speed_press(1);
    press(B_A, 2);
    cyc(10);
    check("mid_update_req", upd_req, 1);
    rst_n = 1'b0;
    #2;
    check("arst_req", upd_req, 0);
    check("arst_running", running, 0);
    check("arst_speed", speed_idx, 1);
    check("arst_steps", step_count, 0);
    check("arst_error", error, 0);
    cyc(2);
    rst_n = 1'b1;
    spd_m = 1;
    ack_mode = 1;
    cyc(3);
    press(B_A, 2);
    cyc(20);
    check("post_rst_steps", step_count, 1);
    check("post_rst_running", running, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
